// File: rtl/conv_result_sink.sv
// conv_result_sink
//
// Receiving end of the convolution engine's result stream. Each valid
// 2*DATA_W-bit sum is requantized to DATA_W bits (round-half-up, saturating),
// tagged with its row/frame position and buffered in a first-word-fall-through
// FIFO that drains over a valid/ready handshake.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   in_data        convolution sum from the engine (2*DATA_W bits)
//   in_valid       in_data valid this cycle; no backpressure toward the engine
//   out_data       requantized pixel at FIFO head
//   out_last_row   head word is the last pixel of a row
//   out_last_frame head word is the last pixel of the frame
//   out_valid      FIFO non-empty
//   out_ready      downstream accepts the head word
//   fifo_level     current occupancy
//   overflow       sticky, set when a sample is dropped
//   frame_done     one-cycle pulse after a last_frame word is popped

module conv_result_sink #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [2*DATA_W-1:0]             in_data,
    input  logic                            in_valid,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_last_row,
    output logic                            out_last_frame,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            frame_done
);

    localparam int unsigned SW = 2 * DATA_W;
    localparam int unsigned EW = DATA_W + 2;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [SW:0] Half = (SW+1)'(1) << (SHIFT - 1);
    localparam logic [SW:0] MaxQ = {{(SW + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    // Requantization: one extra bit keeps the rounding add from wrapping.
    logic [SW:0]       sum_ext;
    logic [SW:0]       q_full;
    logic [DATA_W-1:0] q_sat;

    always_comb begin
        sum_ext = {1'b0, in_data} + Half;
        q_full  = sum_ext >> SHIFT;
        q_sat   = (q_full > MaxQ) ? {DATA_W{1'b1}} : q_full[DATA_W-1:0];
    end

    // Position counters track every valid sample, dropped or not.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          last_row, last_frame;

    always_comb begin
        last_row   = (col_q == CW'(IMG_W - 1));
        last_frame = last_row && (row_q == RW'(IMG_H - 1));
        col_d      = col_q;
        row_d      = row_q;
        if (in_valid) begin
            if (last_row) begin
                col_d = '0;
                row_d = last_frame ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // FIFO storage; pointers carry an extra wrap bit to tell full from empty.
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level;
    logic [EW-1:0] head;
    logic          full, empty, pop, push, drop;
    logic          overflow_q, overflow_d;
    logic          frame_done_q, frame_done_d;

    always_comb begin
        level        = wr_ptr_q - rd_ptr_q;
        full         = (level == (AW+1)'(FIFO_DEPTH));
        empty        = (wr_ptr_q == rd_ptr_q);
        head         = mem_q[rd_ptr_q[AW-1:0]];
        pop          = !empty && out_ready;
        push         = in_valid && (!full || pop);
        drop         = in_valid && full && !pop;
        wr_ptr_d     = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        overflow_d   = overflow_q || drop;
        frame_done_d = pop && head[EW-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {last_frame, last_row, q_sat};
        end
    end

    always_comb begin
        out_valid      = !empty;
        out_data       = empty ? '0 : head[DATA_W-1:0];
        out_last_row   = !empty && head[DATA_W];
        out_last_frame = !empty && head[DATA_W+1];
        fifo_level     = level;
        overflow       = overflow_q;
        frame_done     = frame_done_q;
    end

endmodule

// File: tb/tb_conv_result_sink.sv
module tb_conv_result_sink;

    localparam int unsigned DataW = 8;
    localparam int unsigned Shift = 4;
    localparam int unsigned ImgW  = 4;
    localparam int unsigned ImgH  = 2;
    localparam int unsigned Depth = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  out_data;
    logic        out_last_row;
    logic        out_last_frame;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        frame_done;

    always #5 clk = ~clk;

    conv_result_sink #(
        .DATA_W    (DataW),
        .SHIFT     (Shift),
        .IMG_W     (ImgW),
        .IMG_H     (ImgH),
        .FIFO_DEPTH(Depth)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .out_data      (out_data),
        .out_last_row  (out_last_row),
        .out_last_frame(out_last_frame),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .frame_done    (frame_done)
    );

    int         total = 0;
    int         bad   = 0;
    logic [9:0] sb[$];          // expected {last_frame, last_row, data}
    int         col_m = 0;
    int         row_m = 0;
    logic       exp_ovf = 1'b0;
    logic       exp_fd  = 1'b0;
    int         n_lr = 0;
    int         n_lf = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] rq(input logic [15:0] d);
        int t;
        t = (int'(d) + (1 << (Shift - 1))) >> Shift;
        if (t > 255) return 8'd255;
        return t[7:0];
    endfunction

    // One clock cycle: drive inputs, check state left by the previous edge,
    // update the scoreboard, then advance past the next edge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic [7:0] eq,
                       input logic rdy, input logic drop);
        logic [9:0] head;
        logic       lr, lf;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
        check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        check("out_valid", {31'd0, out_valid}, (sb.size() != 0) ? 32'd1 : 32'd0);
        check("fifo_level", {28'd0, fifo_level}, sb.size());
        exp_fd = 1'b0;
        if (sb.size() != 0) begin
            head = sb[0];
            check("out_data", {24'd0, out_data}, {24'd0, head[7:0]});
            check("out_last_row", {31'd0, out_last_row}, {31'd0, head[8]});
            check("out_last_frame", {31'd0, out_last_frame}, {31'd0, head[9]});
            if (rdy) begin
                void'(sb.pop_front());
                exp_fd = head[9];
                if (out_last_row) n_lr++;
                if (out_last_frame) n_lf++;
            end
        end
        if (v) begin
            lr = (col_m == ImgW - 1);
            lf = lr && (row_m == ImgH - 1);
            col_m = lr ? 0 : col_m + 1;
            if (lr) row_m = lf ? 0 : row_m + 1;
            if (drop) exp_ovf = 1'b1;
            else sb.push_back({lf, lr, eq});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;       // must be ignored during reset
        in_data   = 16'h1234;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        col_m   = 0;
        row_m   = 0;
        exp_ovf = 1'b0;
        exp_fd  = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fifo_level", {28'd0, fifo_level}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_last_row", {31'd0, out_last_row}, 32'd0);
        check("rst_last_frame", {31'd0, out_last_frame}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    endtask

    logic [15:0] rnd_in  [6] = '{16'h0007, 16'h0008, 16'h0037, 16'h0FF7, 16'h0FF8, 16'hFFFF};
    logic [7:0]  rnd_exp [6] = '{8'd0, 8'd1, 8'd3, 8'd255, 8'd255, 8'd255};
    logic        bp_rdy  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [15:0] d;
        logic        v, r;

        do_reset();

        // Rounding and saturation
        for (int i = 0; i < 6; i++) cyc(1'b1, rnd_in[i], rnd_exp[i], 1'b1, 1'b0);
        drain(2);

        // Row/frame tagging, 16 back-to-back samples
        do_reset();
        n_lr = 0;
        n_lf = 0;
        for (int i = 0; i < 16; i++) begin
            d = 16'(i * 37);
            cyc(1'b1, d, rq(d), 1'b1, 1'b0);
        end
        drain(3);
        check("tag_last_row_cnt", n_lr, 32'd4);
        check("tag_last_frame_cnt", n_lf, 32'd2);

        // Overflow: samples 9 and 10 are dropped
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            d = 16'(i << 4);
            cyc(1'b1, d, rq(d), 1'b0, i > 8);
        end
        drain(10);

        // Full FIFO with a simultaneous pop accepts the new word
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            d = 16'(i * 100);
            cyc(1'b1, d, rq(d), 1'b0, 1'b0);
        end
        cyc(1'b1, 16'h0AB0, rq(16'h0AB0), 1'b1, 1'b0);
        drain(10);

        // Backpressure: head must hold while out_ready is low
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = 16'(16'h0200 + i * 16);
            cyc(1'b1, d, rq(d), bp_rdy[i], 1'b0);
        end
        drain(6);

        // Mid-frame reset discards the buffer and restarts position counters
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = 16'(i * 64 + 5);
            cyc(1'b1, d, rq(d), 1'b0, 1'b0);
        end
        cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
        check("mf_level_before_reset", {28'd0, fifo_level}, 32'd3);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d = 16'(i * 300 + 1);
            cyc(1'b1, d, rq(d), 1'b1, 1'b0);
        end
        drain(2);

        // Random traffic
        do_reset();
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            d = 16'($urandom);
            cyc(v, d, rq(d), r, v && (sb.size() == Depth) && !r);
        end
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_result_sink.md
# conv_result_sink

Receiving end of the convolution engine's result stream. Samples each `valid`-qualified `2*DATA_W`-bit convolution sum and requantizes it to `DATA_W` bits with round-half-up and saturation. Tags each sample with row and frame position, then buffers it in a first-word-fall-through FIFO. Results drain to the downstream feature-map writer over a valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, 8, output pixel width; input sum width is `2*DATA_W`
- `SHIFT`, 4, requantization right-shift, range 1..`2*DATA_W-1`
- `IMG_W`, 28, output pixels per row, ≥ 2
- `IMG_H`, 28, rows per frame, ≥ 1
- `FIFO_DEPTH`, 8, buffer entries, power of two, ≥ 2

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous active-low reset
- `in_data`  in  `2*DATA_W`  convolution sum from the engine
- `in_valid`  in  1  `in_data` valid this cycle; no backpressure toward the engine
- `out_data`  out  `DATA_W`  requantized pixel at FIFO head
- `out_last_row`  out  1  head word is the last pixel of a row
- `out_last_frame`  out  1  head word is the last pixel of the frame
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  downstream accepts the head word
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current occupancy
- `overflow`  out  1  sticky; set when a sample is dropped
- `frame_done`  out  1  one-cycle pulse when a `last_frame` word is popped

## Operation
- Requantization is combinational on `in_data`:
  - compute `t = in_data + 2^(SHIFT-1)` in `2*DATA_W+1` bits, so the add never wraps
  - compute `q = t >> SHIFT`
  - if `q > 2^DATA_W-1`, output `2^DATA_W-1`; otherwise output `q[DATA_W-1:0]`
- Position counters `col` (0..`IMG_W-1`) and `row` (0..`IMG_H-1`) advance on every cycle with `in_valid`=1, including cycles where the sample is dropped. This keeps tags aligned with the source stream.
  - `last_row = (col == IMG_W-1)`
  - `last_frame = last_row && (row == IMG_H-1)`
  - `col` wraps to 0 on `last_row`; `row` increments then
  - `row` wraps to 0 on `last_frame`
- FIFO entry is `{last_frame, last_row, q}` (`DATA_W+2` bits). Write and read pointers carry one extra wrap bit.
- Pop = `out_valid && out_ready`.
- Push = `in_valid && (!full || pop)`. A write into a full FIFO is accepted when a pop occurs in the same cycle; occupancy is unchanged.
- Drop = `in_valid && full && !pop`. On a drop, the sample is discarded and `overflow` is set to 1. `overflow` clears only on reset.
- `frame_done` is registered to 1 for exactly one cycle after a pop whose head word has `last_frame`=1.
- FIFO is first-word-fall-through: `out_data`, `out_last_row` and `out_last_frame` always show the head entry. They hold their value while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `out_data`, `out_last_row`, `out_last_frame`, `out_valid`, `fifo_level`, `overflow`, `frame_done` all 0
  - pointers, `col` and `row` are 0
  - `in_valid` is ignored in the reset cycle
- Reset mid-frame discards all buffered words. Counters restart at (0,0).
- Latency: a sample pushed at edge N appears on `out_valid`/`out_data` after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Throughput is one sample per cycle in and one per cycle out sustained. With `out_ready` held at 1 and an empty FIFO, `fifo_level` stays ≤ 1.
- `fifo_level` updates at the same edge as push/pop:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- A pop at empty cannot occur, because `out_valid`=0. `out_ready` is don't-care when `out_valid`=0.
- `out_valid` must never depend combinationally on `out_ready`.

## Test plan
- Rounding/saturation (`SHIFT`=4, `DATA_W`=8), one sample each with `out_ready`=1 → `out_data`:
  - `in_data` 0x0007 → 0
  - 0x0008 → 1
  - 0x0037 → 3
  - 0x0FF7 → 255
  - 0x0FF8 → 255
  - 0xFFFF → 255, no wrap to 0
- Tagging (`IMG_W`=4, `IMG_H`=2): 16 back-to-back samples →
  - `out_last_row`=1 on words 4, 8, 12, 16
  - `out_last_frame`=1 on words 8 and 16
  - `frame_done` pulses one cycle after words 8 and 16 are popped
- Overflow (`FIFO_DEPTH`=8): `out_ready`=0, push 10 samples 1..10 →
  - `fifo_level`=8 after sample 8
  - `overflow`=1 after the edge of sample 9
  - then set `out_ready`=1 → exactly words 1..8 drain in order
  - `overflow` remains 1
- Full with simultaneous pop: fill to 8, then in one cycle assert `in_valid` and `out_ready` →
  - level stays 8
  - `overflow` stays 0
  - the new word is last out
- Backpressure: pushes while `out_ready` toggles 1,0,0,1 → head word held stable during the 0 cycles, with no loss or duplication.
- Mid-frame reset: after 5 pushes with 3 buffered, drive `rst_n`=0 for one cycle →
  - `out_valid`=0 and `fifo_level`=0
  - the next 4 samples with `IMG_W`=4 tag `out_last_row` on the 4th
